edge_pixel_reader: RTL and testbench



---
 rtl/hough_pkg.sv | 26 ++
 rtl/edge_pixel_reader_if.sv | 35 +++
 rtl/raster_counter.sv | 70 +++++++
 rtl/edge_pixel_reader.sv | 180 ++++++++++++++++++
 tb/tb_edge_pixel_reader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hough_pkg.sv
// Shared types and frame constants for the Hough front end (edge reader and voting block).
package hough_pkg;

  localparam int WIDTH      = 720;
  localparam int HEIGHT     = 540;
  localparam int IMAGE_SIZE = WIDTH * HEIGHT;

  localparam int X_W    = $clog2(WIDTH);
  localparam int Y_W    = $clog2(HEIGHT);
  localparam int ADDR_W = $clog2(IMAGE_SIZE);

  typedef enum logic [1:0] {
    sIDLE  = 2'd0,
    sSCAN  = 2'd1,
    sDRAIN = 2'd2,
    sDONE  = 2'd3
  } reader_state_t;

  // Pixel record pushed into the voting FIFO; sized for the full-resolution frame.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [7:0]     mag;
  } edge_pixel_t;

endpackage

// File: rtl/edge_pixel_reader_if.sv
// Handshake bundle between the edge pixel reader, the frame BRAM (port B) and the voting FIFO.
interface edge_pixel_reader_if #(
  parameter int WIDTH  = hough_pkg::WIDTH,
  parameter int HEIGHT = hough_pkg::HEIGHT
) ();

  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic          hough_start;
  logic          bram_rd_en;
  logic [AW-1:0] bram_rd_addr;
  logic [7:0]    bram_rd_data;
  logic          out_wr_en;
  logic          out_full;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [7:0]    out_mag;
  logic          busy;
  logic          reader_done;

  // Reader side.
  modport master (
    input  hough_start, bram_rd_data, out_full,
    output bram_rd_en, bram_rd_addr, out_wr_en, out_x, out_y, out_mag, busy, reader_done
  );

  // Environment side (writer, BRAM, FIFO).
  modport slave (
    output hough_start, bram_rd_data, out_full,
    input  bram_rd_en, bram_rd_addr, out_wr_en, out_x, out_y, out_mag, busy, reader_done
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order col/row/address counter; increments without a multiplier and wraps after the last pixel.
module raster_counter #(
  parameter int WIDTH  = hough_pkg::WIDTH,
  parameter int HEIGHT = hough_pkg::HEIGHT
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              clr_i,
  input  logic                              en_i,
  output logic [$clog2(WIDTH)-1:0]          col_o,
  output logic [$clog2(HEIGHT)-1:0]         row_o,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr_o,
  output logic                              last_o
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_s;

  assign last_s = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Next position: clear wins, then advance with column wrap into the next row.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr_i || (en_i && last_s)) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (en_i) begin
      addr_d = addr_q + AW'(1);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Position registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;
  assign last_o = last_s;

endmodule

// File: rtl/edge_pixel_reader.sv
// Scans the hysteresis frame BRAM in raster order and pushes surviving edge pixels to the voting FIFO.
module edge_pixel_reader #(
  parameter int         WIDTH          = hough_pkg::WIDTH,
  parameter int         HEIGHT         = hough_pkg::HEIGHT,
  parameter logic [7:0] EDGE_THRESHOLD = 8'd0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  edge_pixel_reader_if.master  bus
);

  import hough_pkg::*;

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  typedef logic [XW-1:0] col_t;
  typedef logic [YW-1:0] row_t;

  reader_state_t state_q;
  logic          busy_q;
  logic          done_q;

  col_t          cnt_col_s;
  row_t          cnt_row_s;
  logic [AW-1:0] cnt_addr_s;
  logic          cnt_last_s;
  logic          cnt_clr_s;

  logic          rd_valid_q;
  col_t          rd_col_q;
  row_t          rd_row_q;

  logic          hold_valid_q, hold_valid_d;
  edge_pixel_t   hold_q, hold_d;

  logic          hit_s;
  logic          stall_s;
  logic          rd_en_s;
  logic          wr_en_s;
  col_t          wr_x_s;
  row_t          wr_y_s;
  logic [7:0]    wr_mag_s;

  assign cnt_clr_s = (state_q == sDONE);

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_issue_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (cnt_clr_s),
    .en_i    (rd_en_s),
    .col_o   (cnt_col_s),
    .row_o   (cnt_row_s),
    .addr_o  (cnt_addr_s),
    .last_o  (cnt_last_s)
  );

  // Resolve the returning pixel or the held one; stall issue while a pixel cannot leave.
  always_comb begin
    hit_s        = rd_valid_q && (bus.bram_rd_data > EDGE_THRESHOLD);
    stall_s      = 1'b0;
    wr_en_s      = 1'b0;
    wr_x_s       = '0;
    wr_y_s       = '0;
    wr_mag_s     = 8'd0;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (hold_valid_q) begin
      // No read was issued while holding, so no fresh data competes with the hold.
      stall_s = bus.out_full;
      if (!bus.out_full) begin
        wr_en_s      = 1'b1;
        wr_x_s       = col_t'(hold_q.x);
        wr_y_s       = row_t'(hold_q.y);
        wr_mag_s     = hold_q.mag;
        hold_valid_d = 1'b0;
      end else begin
        hold_valid_d = 1'b1;
      end
    end else if (hit_s) begin
      if (bus.out_full) begin
        stall_s      = 1'b1;
        hold_valid_d = 1'b1;
        hold_d.x     = X_W'(rd_col_q);
        hold_d.y     = Y_W'(rd_row_q);
        hold_d.mag   = bus.bram_rd_data;
      end else begin
        wr_en_s  = 1'b1;
        wr_x_s   = rd_col_q;
        wr_y_s   = rd_row_q;
        wr_mag_s = bus.bram_rd_data;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
    rd_en_s = (state_q == sSCAN) && !stall_s;
  end

  // Frame control FSM with registered busy and done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= sIDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        sIDLE: begin
          // A start coinciding with the done pulse belongs to no frame and is dropped.
          if (bus.hough_start && !done_q) begin
            state_q <= sSCAN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= sIDLE;
          end
        end
        sSCAN: begin
          if (rd_en_s && cnt_last_s) begin
            state_q <= sDRAIN;
          end else begin
            state_q <= sSCAN;
          end
        end
        sDRAIN: begin
          // Done once the final return has left or been discarded and nothing is held.
          if (!hold_valid_d) begin
            state_q <= sDONE;
          end else begin
            state_q <= sDRAIN;
          end
        end
        sDONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= sIDLE;
        end
        default: begin
          state_q <= sIDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline for the in-flight read and the single-entry backpressure hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q   <= 1'b0;
      rd_col_q     <= '0;
      rd_row_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      rd_valid_q <= rd_en_s;
      if (rd_en_s) begin
        rd_col_q <= cnt_col_s;
        rd_row_q <= cnt_row_s;
      end else begin
        rd_col_q <= rd_col_q;
        rd_row_q <= rd_row_q;
      end
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.bram_rd_en   = rd_en_s;
  assign bus.bram_rd_addr = cnt_addr_s;
  assign bus.out_wr_en    = wr_en_s;
  assign bus.out_x        = wr_x_s;
  assign bus.out_y        = wr_y_s;
  assign bus.out_mag      = wr_mag_s;
  assign bus.busy         = busy_q;
  assign bus.reader_done  = done_q;

endmodule

// File: tb/tb_edge_pixel_reader.sv
// Scoreboard bench for edge_pixel_reader on a 4x3 frame.
module tb_edge_pixel_reader;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic [7:0] mag;
  } pix_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  edge_pixel_reader_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  edge_pixel_reader #(.WIDTH(W), .HEIGHT(H), .EDGE_THRESHOLD(8'd0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem [N];
  pix_t       exp_q [$];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0, wr_cnt = 0, last_wr_cyc = 0, start_cyc = 0;

  // BRAM port B model: data one cycle after read enable.
  always @(posedge clock) begin
    if (bus.bram_rd_en) bus.bram_rd_data <= mem[bus.bram_rd_addr];
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every FIFO write, tracks done and busy.
  initial begin
    pix_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (bus.busy) busy_cnt++;
        if (bus.out_wr_en) begin
          wr_cnt++;
          last_wr_cyc = cyc;
          chk("wr_while_full", int'(bus.out_full), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_x", int'(bus.out_x), int'(e.x));
            chk("out_y", int'(bus.out_y), int'(e.y));
            chk("out_mag", int'(bus.out_mag), int'(e.mag));
          end
        end
        if (bus.reader_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int a = 0; a < N; a++) mem[a] = v;
  endtask

  task automatic push_frame();
    pix_t p;
    for (int a = 0; a < N; a++) begin
      if (mem[a] > 8'd0) begin
        p.x = 2'(a % W);
        p.y = 2'(a / W);
        p.mag = mem[a];
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 bus.hough_start = 1'b1;
    @(posedge clock);
    #1 bus.hough_start = 1'b0;
    start_cyc = cyc;
    busy_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    bool_loop: for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (done_cnt != d0) break;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic end_frame(input string tag, input int exp_rel, input int exp_wr, input int wr0, input int d0);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_done_cycle"}, done_cyc - start_cyc + 1, exp_rel);
    chk({tag, "_writes"}, wr_cnt - wr0, exp_wr);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, d0, bad, found;
    bus.hough_start = 1'b0;
    bus.out_full = 1'b0;
    fill(8'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.reader_done), 0);
    chk("rst_rd_en", int'(bus.bram_rd_en), 0);
    chk("rst_wr_en", int'(bus.out_wr_en), 0);
    chk("rst_addr", int'(bus.bram_rd_addr), 0);
    reset_n = 1'b1;

    // 1: empty frame.
    fill(8'd0); push_frame(); wr0 = wr_cnt; d0 = done_cnt;
    pulse_start(); wait_done(100);
    end_frame("t1", 15, 0, wr0, d0);
    chk("t1_busy_cycles", busy_cnt, 14);

    // 2: single pixel at address 5.
    fill(8'd0); mem[5] = 8'h40; push_frame(); wr0 = wr_cnt; d0 = done_cnt;
    pulse_start(); wait_done(100);
    end_frame("t2", 15, 1, wr0, d0);
    chk("t2_write_cycle", last_wr_cyc - start_cyc + 1, 7);

    // 3: full frame, no backpressure.
    fill(8'hFF); push_frame(); wr0 = wr_cnt; d0 = done_cnt;
    pulse_start(); wait_done(100);
    end_frame("t3", 15, 12, wr0, d0);
    chk("t3_last_write_cycle", last_wr_cyc - start_cyc + 1, 13);
    chk("t3_busy_cycles", busy_cnt, 14);

    // 4: FIFO full for 5 cycles from the third write.
    fill(8'hFF); push_frame(); wr0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    fork
      begin
        repeat (3) @(posedge clock);
        #1 bus.out_full = 1'b1;
        repeat (5) @(posedge clock);
        #1 bus.out_full = 1'b0;
      end
      wait_done(200);
    join
    end_frame("t4", 20, 12, wr0, d0);

    // 5: asynchronous reset mid-scan, then a clean rescan.
    fill(8'd0); d0 = done_cnt;
    pulse_start();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.bram_rd_en && bus.bram_rd_addr == 4'd7) begin
        found = 1;
        break;
      end
    end
    chk("t5_reached_addr7", found, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_rd_en", int'(bus.bram_rd_en), 0);
    chk("t5_rst_addr", int'(bus.bram_rd_addr), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_outs", int'({bus.out_wr_en, bus.out_x, bus.out_y, bus.out_mag, bus.reader_done}), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.busy || bus.bram_rd_en) bad++;
    end
    chk("t5_idle_after_reset", bad, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    mem[0] = 8'h11; push_frame(); wr0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    @(negedge clock);
    chk("t5_rescan_rd_en", int'(bus.bram_rd_en), 1);
    chk("t5_rescan_addr", int'(bus.bram_rd_addr), 0);
    wait_done(100);
    end_frame("t5", 15, 1, wr0, d0);

    // 6: start re-pulsed during scan and again on the done cycle.
    fill(8'd0); mem[11] = 8'h22; push_frame(); wr0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    fork
      begin
        repeat (4) @(posedge clock);
        #1 bus.hough_start = 1'b1;
        @(posedge clock);
        #1 bus.hough_start = 1'b0;
      end
      wait_done(100);
    join
    end_frame("t6", 15, 1, wr0, d0);
    bus.hough_start = 1'b1;
    @(posedge clock);
    #1 bus.hough_start = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.busy || bus.bram_rd_en) bad++;
    end
    chk("t6_start_on_done_ignored", bad, 0);
    chk("t6_single_done", done_cnt - d0, 1);

    // 7: last pixel hits while FIFO is full; done waits for it.
    fill(8'd0); mem[11] = 8'h22; push_frame(); wr0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    fork
      begin
        repeat (12) @(posedge clock);
        #1 bus.out_full = 1'b1;
        repeat (3) @(posedge clock);
        #1 bus.out_full = 1'b0;
      end
      wait_done(100);
    join
    end_frame("t7", 18, 1, wr0, d0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
